// File: rtl/dec38_pkg.sv
// Shared types and constants for the dec38_led code display path.
package dec38_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_D0 = 7'h40;
    localparam logic [6:0] SEG_D1 = 7'h79;
    localparam logic [6:0] SEG_D2 = 7'h24;
    localparam logic [6:0] SEG_D3 = 7'h30;
    localparam logic [6:0] SEG_D4 = 7'h19;
    localparam logic [6:0] SEG_D5 = 7'h12;
    localparam logic [6:0] SEG_D6 = 7'h02;
    localparam logic [6:0] SEG_D7 = 7'h78;

endpackage

// File: rtl/dec38_led_bcd7seg.sv
// bcd7seg: combinational 0..7 digit to active-low seven-segment pattern, with blanking.
module bcd7seg
    import dec38_pkg::*;
(
    input  logic [2:0] code_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (code_i)
                3'd0: seg_o = SEG_D0;
                3'd1: seg_o = SEG_D1;
                3'd2: seg_o = SEG_D2;
                3'd3: seg_o = SEG_D3;
                3'd4: seg_o = SEG_D4;
                3'd5: seg_o = SEG_D5;
                3'd6: seg_o = SEG_D6;
                3'd7: seg_o = SEG_D7;
            endcase
        end
    end

endmodule

// File: rtl/dec38_led.sv
// Registered 3-to-8 decoder that holds each accepted code on the LEDs for HOLD_CYCLES cycles.
// Optional seven-segment output seg0 is built when DEC38_SEG_EN is defined.
module dec38_led
    import dec38_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    input  logic       in_vx,
    output logic [7:0] led,
    output logic       led_valid,
    output logic       done
`ifdef DEC38_SEG_EN
    ,
    output logic [6:0] seg0
`endif
);

    localparam logic [15:0] HOLD_M1 = 16'(HOLD_CYCLES - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [7:0]  led_q;
    logic [7:0]  led_d;
    logic        led_valid_q;
    logic        done_q;
    logic        hold_end;
    logic        accept;

    // The last held cycle doubles as the window for taking the next code, so streams have no gap.
    assign hold_end = (state_q == ST_SHOW) && (cnt_q == 16'd0);
    assign in_ready = !rst && ((state_q == ST_IDLE) || hold_end);
    assign accept   = in_valid && in_ready;
    assign led_d    = in_vx ? (8'd1 << in_code) : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            led_q       <= 8'h00;
            led_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= hold_end;
            if (accept) begin
                state_q     <= ST_SHOW;
                cnt_q       <= HOLD_M1;
                led_q       <= led_d;
                led_valid_q <= 1'b1;
            end else if (state_q == ST_SHOW) begin
                if (cnt_q != 16'd0) begin
                    cnt_q <= cnt_q - 16'd1;
                end else begin
                    state_q     <= ST_IDLE;
                    led_q       <= 8'h00;
                    led_valid_q <= 1'b0;
                end
            end
        end
    end

    assign led       = led_q;
    assign led_valid = led_valid_q;
    assign done      = done_q;

`ifdef DEC38_SEG_EN
    logic [6:0] seg_d;
    logic [6:0] seg_q;

    bcd7seg u_bcd7seg (
        .code_i  (in_code),
        .blank_i (!in_vx),
        .seg_o   (seg_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
        end else if (accept) begin
            seg_q <= seg_d;
        end else if (hold_end) begin
            seg_q <= SEG_BLANK;
        end
    end

    assign seg0 = seg_q;
`endif

endmodule

// File: tb/tb_dec38_led.sv
// Bench for dec38_led: DUT A with HOLD_CYCLES=4, DUT B with HOLD_CYCLES=1, against an edge-time model.
module tb_dec38_led;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       va = 1'b0, vb = 1'b0;
    logic [2:0] ca = 3'd0, cb = 3'd0;
    logic       xa = 1'b0, xb = 1'b0;
    logic       rdy_a, rdy_b, lv_a, lv_b, done_a, done_b;
    logic [7:0] led_a, led_b;
    logic [6:0] seg_a, seg_b;

    always #5 clk = ~clk;

    dec38_led #(.HOLD_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(va), .in_ready(rdy_a), .in_code(ca), .in_vx(xa),
        .led(led_a), .led_valid(lv_a), .done(done_a)
`ifdef DEC38_SEG_EN
        , .seg0(seg_a)
`endif
    );

    dec38_led #(.HOLD_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rdy_b), .in_code(cb), .in_vx(xb),
        .led(led_b), .led_valid(lv_b), .done(done_b)
`ifdef DEC38_SEG_EN
        , .seg0(seg_b)
`endif
    );

`ifndef DEC38_SEG_EN
    assign seg_a = 7'h7F;
    assign seg_b = 7'h7F;
`endif

    // Reference model: each hold is tracked by the absolute edge number at which it ends.
    int         nvec = 0;
    int         nerr = 0;
    int         ecount = 0;
    int         hold[2] = '{4, 1};
    logic [7:0] m_led[2] = '{8'h00, 8'h00};
    logic       m_active[2] = '{1'b0, 1'b0};
    logic       m_done[2] = '{1'b0, 1'b0};
    logic [6:0] m_seg[2] = '{7'h7F, 7'h7F};
    int         m_end[2] = '{0, 0};
    logic [6:0] segt[8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

    function automatic logic m_rdy(input int i);
        return !rst && (!m_active[i] || (ecount + 1) == m_end[i]);
    endfunction

    function automatic logic [17:0] expv(input int i);
        return {m_led[i], m_active[i], m_done[i], m_rdy(i), m_seg[i]};
    endfunction

    function automatic logic [17:0] obs(input int i);
        if (i == 0) return {led_a, lv_a, done_a, rdy_a, seg_a};
        return {led_b, lv_b, done_b, rdy_b, seg_b};
    endfunction

    task automatic step();
        logic       acc[2];
        logic       vx[2];
        logic [2:0] cd[2];
        acc[0] = va && m_rdy(0);
        acc[1] = vb && m_rdy(1);
        vx[0] = xa; vx[1] = xb;
        cd[0] = ca; cd[1] = cb;
        @(posedge clk);
        ecount++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_active[i] = 1'b0; m_led[i] = 8'h00; m_done[i] = 1'b0; m_seg[i] = 7'h7F;
            end else begin
                m_done[i] = m_active[i] && (ecount == m_end[i]);
                if (acc[i]) begin
                    m_active[i] = 1'b1;
                    m_end[i]    = ecount + hold[i];
                    m_led[i]    = vx[i] ? 8'(1 << cd[i]) : 8'h00;
`ifdef DEC38_SEG_EN
                    m_seg[i]    = vx[i] ? segt[cd[i]] : 7'h7F;
`endif
                end else if (m_active[i] && ecount == m_end[i]) begin
                    m_active[i] = 1'b0; m_led[i] = 8'h00; m_seg[i] = 7'h7F;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; va = 1'b0; vb = 1'b0;
        step(); step();
        for (int i = 0; i < 2; i++) begin
            nvec++;
            if (obs(i) !== expv(i)) begin
                nerr++; $display("FAIL reset dut%0d got=%h want=%h", i, obs(i), expv(i));
            end
        end
        rst = 1'b0; #1;
        nvec++;
        if ({rdy_a, rdy_b} !== 2'b11) begin
            nerr++; $display("FAIL reset_ready got=%b want=11", {rdy_a, rdy_b});
        end
    endtask

    task automatic test_single();
        va = 1'b1; ca = 3'd5; xa = 1'b1;
        step();
        va = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            ca = 3'($urandom);
            nvec++;
            if (obs(0) !== expv(0)) begin
                nerr++; $display("FAIL single k=%0d got=%h want=%h", k, obs(0), expv(0));
            end
            nvec++;
            if (k < 4 && led_a !== 8'h20) begin
                nerr++; $display("FAIL single_led k=%0d got=%h want=20", k, led_a);
            end else if (k == 4 && {done_a, lv_a, led_a} !== 10'h200) begin
                nerr++; $display("FAIL single_end got=%h want=200", {done_a, lv_a, led_a});
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int nd = 0;
        for (int k = 0; k < 10; k++) begin
            va = (k < 5); ca = (k == 0) ? 3'd3 : 3'd7; xa = 1'b1;
            step();
            if (done_a === 1'b1) nd++;
            nvec++;
            if (obs(0) !== expv(0)) begin
                nerr++; $display("FAIL b2b k=%0d got=%h want=%h", k, obs(0), expv(0));
            end
            nvec++;
            if (k < 8 && led_a !== ((k < 4) ? 8'h08 : 8'h80)) begin
                nerr++; $display("FAIL b2b_led k=%0d got=%h", k, led_a);
            end
        end
        va = 1'b0;
        nvec++;
        if (nd != 2) begin
            nerr++; $display("FAIL b2b_done_count got=%0d want=2", nd);
        end
    endtask

    task automatic test_vx0();
        va = 1'b1; ca = 3'd6; xa = 1'b0;
        step();
        va = 1'b0;
        for (int k = 0; k < 5; k++) begin
            nvec++;
            if (obs(0) !== expv(0)) begin
                nerr++; $display("FAIL vx0 k=%0d got=%h want=%h", k, obs(0), expv(0));
            end
            nvec++;
            if (k < 4 && {led_a, lv_a, seg_a} !== 16'h00FF) begin
                nerr++; $display("FAIL vx0_hold k=%0d got=%h want=00ff", k, {led_a, lv_a, seg_a});
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        va = 1'b1; ca = 3'd2; xa = 1'b1;
        step();
        va = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; #1;
        nvec++;
        if ({led_a, lv_a, done_a, rdy_a} !== 11'h001) begin
            nerr++; $display("FAIL rst_mid got=%h want=001", {led_a, lv_a, done_a, rdy_a});
        end
        for (int k = 0; k < 4; k++) begin
            step();
            nvec++;
            if (obs(0) !== expv(0)) begin
                nerr++; $display("FAIL rst_mid_after k=%0d got=%h want=%h", k, obs(0), expv(0));
            end
        end
    endtask

    task automatic test_hold1();
        for (int k = 0; k < 8; k++) begin
            vb = 1'b1; cb = 3'(k); xb = 1'b1;
            step();
            nvec++;
            if (obs(1) !== expv(1)) begin
                nerr++; $display("FAIL hold1 k=%0d got=%h want=%h", k, obs(1), expv(1));
            end
            nvec++;
            if (led_b !== 8'(1 << k) || (k > 0 && done_b !== 1'b1)) begin
                nerr++; $display("FAIL hold1_step k=%0d got=%h/%b", k, led_b, done_b);
            end
        end
        vb = 1'b0;
        step();
        nvec++;
        if ({led_b, lv_b, done_b} !== 10'h001) begin
            nerr++; $display("FAIL hold1_end got=%h want=001", {led_b, lv_b, done_b});
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 49) == 0);
            va = $urandom_range(0, 3) != 0; ca = 3'($urandom); xa = $urandom_range(0, 5) != 0;
            vb = $urandom_range(0, 2) != 0; cb = 3'($urandom); xb = $urandom_range(0, 5) != 0;
            step();
            for (int i = 0; i < 2; i++) begin
                nvec++;
                if (obs(i) !== expv(i)) begin
                    nerr++; $display("FAIL random k=%0d dut%0d got=%h want=%h", k, i, obs(i), expv(i));
                end
            end
        end
        rst = 1'b0; va = 1'b0; vb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_vx0();
        test_reset_mid();
        test_hold1();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dec38_led.md
# dec38_led

Registered 3-to-8 decoder with a display hold timer, the receiving end of the 8-to-3 priority-encoder path. It accepts a 3-bit code plus its valid flag through a valid/ready handshake and drives a one-hot 8-LED pattern for a fixed number of cycles. It optionally drives a seven-segment digit showing the code. It sits between the encoder output and the board LED/segment pins.

## Interface
- HOLD_CYCLES, default 4: cycles each accepted code stays displayed; legal range 1..65535.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  producer has a code on in_code/in_vx.
- in_ready  out  1  block can accept this cycle; combinational from state and counter.
- in_code  in  3  encoded index 0..7.
- in_vx  in  1  encoder valid flag; 0 means "no input bit set".
- led  out  8  registered one-hot pattern.
- led_valid  out  1  registered; high while a pattern is being held.
- done  out  1  registered one-cycle pulse after each hold period ends.
- seg0  out  7  active-low segment drive; present only with DEC38_SEG_EN.

## Operation
- States: IDLE and SHOW. Counter `cnt` is 16 bits wide.
- in_ready is 1 in IDLE, and 1 in SHOW only when cnt==0. It is forced to 0 while rst=1.
- An accept is a rising edge with in_valid && in_ready.
- On accept, registers update as follows:
  - led = in_vx ? (8'b1 << in_code) : 8'h00.
  - led_valid = 1.
  - cnt = HOLD_CYCLES-1.
  - state = SHOW.
  - in_vx=0 is accepted and held like any other code, with an all-zero pattern.
- In SHOW with cnt!=0: cnt decrements, led is held, and in_ready=0. Inputs are ignored.
- In SHOW with cnt==0 and an accept: the new pattern loads immediately, the state stays SHOW, and there is no gap cycle.
- In SHOW with cnt==0 and no accept: state goes to IDLE, led=0, led_valid=0.
- done is registered to 1 on the edge that ends a hold period, whether or not a new code is accepted on that edge. It is 0 on every other cycle.
- Inputs outside an accept are don't-care. in_code is sampled only on an accept.

## Timing
- Reset values:
  - state=IDLE, cnt=0.
  - led=8'h00, led_valid=0, done=0.
  - seg0=7'h7F (blank).
- Reset is honoured in any state. A hold in progress is abandoned, and the next cycle is IDLE.
- Latency: for an accept at edge N, led/led_valid are valid after edge N, one cycle after presentation.
- The pattern is held from edge N to edge N+HOLD_CYCLES, exactly HOLD_CYCLES cycles.
- done is high in the cycle following edge N+HOLD_CYCLES.
- HOLD_CYCLES=1: in_ready is high every cycle, so a new code can be accepted on every edge. done pulses each cycle while the stream continues.
- Maximum throughput is one code per HOLD_CYCLES cycles.

## Configuration
- DEC38_SEG_EN defined:
  - seg0 exists and is registered alongside led.
  - On an accept, seg0 is updated to the active-low pattern for digit in_code (0..7) when in_vx=1, and to blank (7'h7F) when in_vx=0.
  - seg0 is blank whenever led_valid=0.
- DEC38_SEG_EN undefined: seg0 port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package dec38_pkg holds:
  - the state enum (ST_IDLE, ST_SHOW);
  - localparam SEG_BLANK = 7'h7F;
  - the digit segment constants 0..7.
- One sub-module is used: the existing bcd7seg, instantiated only under DEC38_SEG_EN. Its output is registered in dec38_led.

## Test plan
- Reset, then idle:
  - During and after rst: led=00, led_valid=0, done=0, seg0=7F.
  - After reset: in_ready=1.
- HOLD_CYCLES=4, accept code=5, vx=1, then in_valid=0:
  - led=8'h20 for 4 cycles, in_ready=0 for the first 3 of them.
  - Then done=1 for one cycle, and led=00, led_valid=0.
- Back-to-back codes 3 then 7, with in_valid held high:
  - led=08 for 4 cycles, then 80 for 4 cycles, with no gap.
  - done pulses once at the switch and once at the end.
- Accept vx=0, code=6: led=00 with led_valid=1 for 4 cycles; seg0=7F.
- Assert rst for one cycle two cycles into a hold: led=00, led_valid=0 and in_ready=1 on the next cycle; done is not pulsed.
- HOLD_CYCLES=1, accept codes 0..7 on consecutive cycles: led steps 01,02,…,80 one cycle each; done pulses after every hold.
